// File: rtl/bsg_sdr_link_packetizer_if.sv
// Core-message and SDR-link flit bundle for the link packetizer.
// slave = packetizer side, master = core/pearl side driving messages and credits.
interface bsg_sdr_link_packetizer_if #(
    parameter int msg_width_p  = 128,
    parameter int flit_width_p = 32
);
    localparam int max_flits_lp = (msg_width_p + flit_width_p - 1) / flit_width_p;
    localparam int len_width_lp = (max_flits_lp <= 1) ? 1 : $clog2(max_flits_lp);

    logic [msg_width_p-1:0]  msg_data;
    logic [len_width_lp-1:0] msg_len;
    logic                    msg_v;
    logic                    msg_ready_and;
    logic [flit_width_p-1:0] link_data;
    logic                    link_v;
    logic                    link_credit;
    logic                    error;

    modport slave (
        input  msg_data, msg_len, msg_v, link_credit,
        output msg_ready_and, link_data, link_v, error
    );

    modport master (
        output msg_data, msg_len, msg_v, link_credit,
        input  msg_ready_and, link_data, link_v, error
    );
endinterface

// File: rtl/bsg_sdr_link_packetizer.sv
// Splits one wide core message into a length header flit plus len+1 payload flits for the SDR link.
// Latency: header on link_v one cycle after accept, then one flit per cycle while credits last.
// Backpressure: local credit counter mirrors the pearl input FIFO; at zero credits the flit is held stable.
module bsg_sdr_link_packetizer #(
    parameter int msg_width_p  = 128,
    parameter int flit_width_p = 32,
    parameter int credits_p    = 3
) (
    input  logic                          core_clk_i,
    input  logic                          core_reset_n_i,
    bsg_sdr_link_packetizer_if.slave      link
);
    localparam int max_flits_lp = (msg_width_p + flit_width_p - 1) / flit_width_p;
    localparam int len_width_lp = (max_flits_lp <= 1) ? 1 : $clog2(max_flits_lp);
    localparam int cnt_width_lp = ((credits_p + 1) <= 1) ? 1 : $clog2(credits_p + 1);
    localparam int pad_width_lp = max_flits_lp * flit_width_p;

    localparam logic [len_width_lp-1:0] len_max_lp     = len_width_lp'(max_flits_lp - 1);
    localparam logic [len_width_lp:0]   len_max_ext_lp = (len_width_lp + 1)'(max_flits_lp - 1);
    localparam logic [cnt_width_lp-1:0] cnt_full_lp    = cnt_width_lp'(credits_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_e;

    typedef struct packed {
        logic [flit_width_p-len_width_lp-1:0] rsvd;
        logic [len_width_lp-1:0]              len;
    } hdr_t;

    state_e                                     state_q, state_n;
    logic [cnt_width_lp-1:0]                    cnt_q;
    logic [len_width_lp-1:0]                    idx_q, idx_n;
    logic [len_width_lp-1:0]                    len_q;
    logic [max_flits_lp-1:0][flit_width_p-1:0]  msg_q;
    logic                                       error_q;

    logic                    credit_ok;
    logic                    send;
    logic                    last;
    logic                    accept;
    logic                    len_ovf;
    logic [len_width_lp-1:0] len_in;
    logic [pad_width_lp-1:0] msg_pad;
    logic                    credit_ovf;
    hdr_t                    hdr;

    assign credit_ok = (cnt_q != '0);
    assign send      = (state_q != IDLE) && credit_ok;
    assign last      = (idx_q == len_q);

    // Ready only from registered state: IDLE, or the final payload flit leaving this cycle.
    assign link.msg_ready_and = (state_q == IDLE) || ((state_q == BODY) && last && credit_ok);
    assign accept             = link.msg_v && link.msg_ready_and;

    assign len_ovf = {1'b0, link.msg_len} > len_max_ext_lp;
    assign len_in  = len_ovf ? len_max_lp : link.msg_len;
    assign msg_pad = pad_width_lp'(link.msg_data);

    assign credit_ovf = link.link_credit && !send && (cnt_q == cnt_full_lp);

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
        end
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_n = HDR;
            end
            HDR: begin
                if (send) begin
                    state_n = BODY;
                    idx_n   = '0;
                end
            end
            BODY: begin
                if (send) begin
                    if (last) begin
                        state_n = accept ? HDR : IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_q + len_width_lp'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            msg_q <= '0;
            len_q <= '0;
        end else if (accept) begin
            msg_q <= msg_pad;
            len_q <= len_in;
        end
    end

    // A send and a returned credit in the same cycle cancel out.
    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            cnt_q <= cnt_full_lp;
        end else if (send && !link.link_credit) begin
            cnt_q <= cnt_q - cnt_width_lp'(1);
        end else if (link.link_credit && !send && (cnt_q != cnt_full_lp)) begin
            cnt_q <= cnt_q + cnt_width_lp'(1);
        end
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            error_q <= 1'b0;
        end else if (credit_ovf || (accept && len_ovf)) begin
            error_q <= 1'b1;
        end
    end

    always_comb begin
        hdr            = '0;
        hdr.len        = len_q;
        link.link_data = '0;
        unique case (state_q)
            HDR:     link.link_data = hdr;
            BODY:    link.link_data = msg_q[idx_q];
            default: link.link_data = '0;
        endcase
    end

    assign link.link_v = send;
    assign link.error  = error_q;

endmodule

// File: tb/tb_bsg_sdr_link_packetizer.sv
// Randomized and directed bench for the SDR link packetizer against a flit-queue reference model.
module tb_bsg_sdr_link_packetizer;
    localparam int MW = 160;
    localparam int FW = 32;
    localparam int CR = 3;
    localparam int MF = (MW + FW - 1) / FW;
    localparam int LW = (MF <= 1) ? 1 : $clog2(MF);

    typedef struct {
        logic [MW-1:0] data;
        logic [LW-1:0] len;
    } msg_s;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bsg_sdr_link_packetizer_if #(.msg_width_p(MW), .flit_width_p(FW)) bus ();

    bsg_sdr_link_packetizer #(
        .msg_width_p (MW),
        .flit_width_p(FW),
        .credits_p   (CR)
    ) dut (
        .core_clk_i    (clk),
        .core_reset_n_i(rst_n),
        .link          (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    msg_s          src[$];
    logic [FW-1:0] q[$];
    int            m_cred;
    bit            m_err;
    int            pend;
    int            cmode;
    int            flits_sent;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input msg_s m);
        int l;
        l = int'(m.len);
        if (l > MF - 1) begin
            l     = MF - 1;
            m_err = 1'b1;
        end
        q.push_back(FW'(l));
        for (int k = 0; k <= l; k++) q.push_back(m.data[k*FW +: FW]);
    endtask

    task automatic drive_src();
        if (src.size() != 0) begin
            bus.msg_v    = 1'b1;
            bus.msg_data = src[0].data;
            bus.msg_len  = src[0].len;
        end else begin
            bus.msg_v = 1'b0;
        end
    endtask

    task automatic tick();
        bit exp_v, exp_rdy, hs, cr;
        @(negedge clk);
        exp_v   = (q.size() != 0) && (m_cred != 0);
        exp_rdy = (q.size() == 0) || ((q.size() == 1) && (m_cred != 0));
        check("link_v", 64'(bus.link_v), 64'(exp_v));
        check("msg_ready", 64'(bus.msg_ready_and), 64'(exp_rdy));
        check("error", 64'(bus.error), 64'(m_err));
        if (q.size() != 0) check("link_data", 64'(bus.link_data), 64'(q[0]));
        hs = bus.msg_v && exp_rdy;
        cr = bus.link_credit;
        @(posedge clk);
        if (exp_v) begin
            void'(q.pop_front());
            flits_sent++;
            pend++;
        end
        if (cr && !exp_v) begin
            if (m_cred == CR) m_err = 1'b1;
            else m_cred++;
        end else if (exp_v && !cr) begin
            m_cred--;
        end
        if (hs) model_accept(src.pop_front());
        #1;
        bus.link_credit = 1'b0;
        if ((cmode == 1 && pend > 0) || (cmode == 2 && pend > 0 && $urandom_range(0, 1) == 1)) begin
            bus.link_credit = 1'b1;
            pend--;
        end
        drive_src();
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.msg_v       = 1'b0;
        bus.msg_data    = '0;
        bus.msg_len     = '0;
        bus.link_credit = 1'b0;
        src.delete();
        q.delete();
        m_cred     = CR;
        m_err      = 1'b0;
        pend       = 0;
        flits_sent = 0;
        #1;
        check("rst link_v", 64'(bus.link_v), 64'd0);
        check("rst link_data", 64'(bus.link_data), 64'd0);
        check("rst msg_ready", 64'(bus.msg_ready_and), 64'd1);
        check("rst error", 64'(bus.error), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (src.size() != 0 || q.size() != 0); i++) tick();
        check("drain", 64'(src.size() + q.size()), 64'd0);
    endtask

    function automatic msg_s mk(input logic [MW-1:0] d, input logic [LW-1:0] l);
        msg_s m;
        m.data = d;
        m.len  = l;
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_data();
        logic [MW-1:0] d;
        for (int w = 0; w < MF; w++) d[w*FW +: FW] = $urandom();
        return d;
    endfunction

    initial begin
        logic [MW-1:0] d4;
        d4 = MW'(128'h4444_4444_3333_3333_2222_2222_1111_1111);
        bus.msg_v       = 1'b0;
        bus.msg_data    = '0;
        bus.msg_len     = '0;
        bus.link_credit = 1'b0;
        cmode           = 0;

        // single message, credits returned one cycle after each flit
        do_reset();
        cmode = 1;
        src.push_back(mk(d4, LW'(3)));
        drive_src();
        drain(30);
        check("t1 flits", 64'(flits_sent), 64'd5);

        // no credits returned: three flits then hold, one credit releases the next
        do_reset();
        cmode = 0;
        src.push_back(mk(d4, LW'(3)));
        drive_src();
        repeat (8) tick();
        check("t2 stalled flits", 64'(flits_sent), 64'd3);
        bus.link_credit = 1'b1;
        tick();
        tick();
        check("t2 after pulse", 64'(flits_sent), 64'd4);
        cmode = 1;
        drain(30);

        // back-to-back single-flit messages
        do_reset();
        cmode = 1;
        src.push_back(mk(rand_data(), LW'(0)));
        src.push_back(mk(rand_data(), LW'(0)));
        drive_src();
        drain(30);
        check("t3 flits", 64'(flits_sent), 64'd4);

        // spurious credit at full count: saturate and flag error
        do_reset();
        cmode           = 0;
        bus.link_credit = 1'b1;
        tick();
        repeat (4) tick();
        check("t4 error sticky", 64'(bus.error), 64'd1);
        src.push_back(mk(d4, LW'(3)));
        drive_src();
        repeat (8) tick();
        check("t4 credit saturated", 64'(flits_sent), 64'd3);

        // oversize length is clamped
        do_reset();
        cmode = 1;
        src.push_back(mk(rand_data(), LW'(7)));
        drive_src();
        drain(30);
        check("t5 flits", 64'(flits_sent), 64'(MF + 1));
        check("t5 error", 64'(bus.error), 64'd1);

        // reset in the middle of a message
        do_reset();
        cmode = 1;
        src.push_back(mk(d4, LW'(3)));
        drive_src();
        for (int i = 0; i < 10 && flits_sent < 2; i++) tick();
        check("t6 pre-reset flits", 64'(flits_sent), 64'd2);
        do_reset();
        cmode = 0;
        src.push_back(mk(d4, LW'(3)));
        drive_src();
        repeat (8) tick();
        check("t6 credit restored", 64'(flits_sent), 64'd3);

        // randomized traffic with random credit return
        do_reset();
        cmode = 2;
        for (int i = 0; i < 400; i++) begin
            if (src.size() == 0 && $urandom_range(0, 2) == 0) begin
                src.push_back(mk(rand_data(), LW'($urandom_range(0, MF - 1))));
                drive_src();
            end
            tick();
        end
        cmode = 1;
        drain(200);
        check("t7 no error", 64'(bus.error), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
